raytracer_frag_scheduler: RTL

//  Sequences one frame of rendering once the scene payload has been loaded into the coprocessor.

---
 rtl/raytracer_frag_scheduler.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/raytracer_frag_scheduler.sv
// Frame sequencer for the ray-tracing coprocessor: dispatches fragment indices to render
// cores round-robin and merges their per-fragment result packets onto one AXIS master.
module raytracer_frag_scheduler #(
  parameter int NUM_CORES     = 4,
  parameter int FRAG_IDX_W    = 16,
  parameter int FRAGMENT_SIZE = 64,
  parameter int DATA_W        = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        start,
  input  logic [FRAG_IDX_W-1:0]       num_fragments,
  output logic                        busy,
  output logic                        done,
  input  logic [NUM_CORES-1:0]        core_req,
  output logic [NUM_CORES-1:0]        core_grant,
  output logic [FRAG_IDX_W-1:0]       core_frag_idx,
  input  logic [NUM_CORES-1:0]        core_tvalid,
  input  logic [NUM_CORES*DATA_W-1:0] core_tdata,
  output logic [NUM_CORES-1:0]        core_tready,
  output logic                        m_axis_tvalid,
  output logic [DATA_W-1:0]           m_axis_tdata,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready
);
  localparam int CIDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int WCNT_W = (FRAGMENT_SIZE > 1) ? $clog2(FRAGMENT_SIZE) : 1;
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(FRAGMENT_SIZE - 1);

  typedef enum logic {IDLE, RUN} frame_state_t;
  typedef enum logic {OA_IDLE, OA_LOCK} oa_state_t;

  frame_state_t state_q, state_d;
  oa_state_t    oa_q, oa_d;
  logic [FRAG_IDX_W-1:0] num_q, num_d, disp_q, disp_d, comp_q, comp_d;
  logic [CIDX_W-1:0]     gptr_q, gptr_d, optr_q, optr_d, sel_q, sel_d;
  logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
  logic [CIDX_W-1:0]     gsel, osel;

  function automatic logic [CIDX_W-1:0] wrap_inc(input logic [CIDX_W-1:0] i);
    int unsigned n;
    n = (32'(i) + 1) % NUM_CORES;
    return CIDX_W'(n);
  endfunction

  // First set bit of v at or after start_at, wrapping around.
  function automatic logic [CIDX_W-1:0] rr_pick(input logic [NUM_CORES-1:0] v,
                                                input logic [CIDX_W-1:0]    start_at);
    logic [CIDX_W-1:0] pick;
    logic              found;
    pick  = start_at;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      int unsigned idx;
      idx = (32'(start_at) + k) % NUM_CORES;
      if (!found && v[CIDX_W'(idx)]) begin
        pick  = CIDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    state_d       = state_q;
    oa_d          = oa_q;
    num_d         = num_q;
    disp_d        = disp_q;
    comp_d        = comp_q;
    gptr_d        = gptr_q;
    optr_d        = optr_q;
    sel_d         = sel_q;
    wcnt_d        = wcnt_q;
    busy          = 1'b0;
    done          = 1'b0;
    core_grant    = '0;
    core_frag_idx = '0;
    core_tready   = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    gsel          = rr_pick(core_req, gptr_q);
    osel          = rr_pick(core_tvalid, optr_q);

    case (oa_q)
      OA_IDLE: begin
        if (|core_tvalid) begin
          sel_d  = osel;
          optr_d = wrap_inc(osel);
          wcnt_d = '0;
          oa_d   = OA_LOCK;
        end
      end
      OA_LOCK: begin
        m_axis_tvalid      = core_tvalid[sel_q];
        m_axis_tdata       = core_tdata[sel_q*DATA_W +: DATA_W];
        m_axis_tlast       = (wcnt_q == LAST_WORD);
        core_tready[sel_q] = m_axis_tready;
        if (m_axis_tvalid && m_axis_tready) begin
          if (m_axis_tlast) begin
            wcnt_d = '0;
            comp_d = comp_q + FRAG_IDX_W'(1);
            oa_d   = OA_IDLE;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end
      end
      default: oa_d = OA_IDLE;
    endcase

    // Frame control sits after the arbiter so a start clears a same-cycle completion.
    case (state_q)
      IDLE: begin
        if (start) begin
          num_d   = num_fragments;
          disp_d  = '0;
          comp_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (comp_q == num_q) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          busy = 1'b1;
        end
        if ((disp_q < num_q) && (|core_req)) begin
          core_grant[gsel] = 1'b1;
          core_frag_idx    = disp_q;
          disp_d           = disp_q + FRAG_IDX_W'(1);
          gptr_d           = wrap_inc(gsel);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      oa_q    <= OA_IDLE;
      num_q   <= '0;
      disp_q  <= '0;
      comp_q  <= '0;
      gptr_q  <= '0;
      optr_q  <= '0;
      sel_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      oa_q    <= oa_d;
      num_q   <= num_d;
      disp_q  <= disp_d;
      comp_q  <= comp_d;
      gptr_q  <= gptr_d;
      optr_q  <= optr_d;
      sel_q   <= sel_d;
      wcnt_q  <= wcnt_d;
    end
  end
endmodule
